rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter GFX_BASE, default 25'h0100000, first byte address routed to port 2 (gfx banks 2,3).
REQ-002 clk  in  1  SDRAM clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 ioctl_download  in  1  high for the duration of a ROM download.
REQ-005 ioctl_wr  in  1  one-cycle byte strobe.
REQ-006 ioctl_addr  in  25  byte address.
REQ-007 ioctl_dout  in  8  byte data.
REQ-008 ioctl_wait  out  1  backpressure to the download source.
REQ-009 port1_req/port1_ack  out/in  1/1  toggle handshake, banks 0,1.
REQ-010 port1_we, port1_a[23:1], port1_ds[1:0], port1_d[15:0]  out  write qualifiers for port 1.
REQ-011 port2_req/port2_ack, port2_we, port2_a[23:1], port2_ds[1:0], port2_d[15:0]  same set for port 2.
REQ-012 load_done  out  1  all download bytes committed to SDRAM.
REQ-013 overrun  out  1  sticky: a byte was dropped.

Function
REQ-014 Byte lanes: even byte -> d[15:8], ds bit 1; odd byte -> d[7:0], ds bit 0.
REQ-015 Routing: ioctl_addr < GFX_BASE -> port 1, a = ioctl_addr[23:1]; else port 2, a = (ioctl_addr - GFX_BASE)[23:1] (25-bit subtract, truncated).
REQ-016 States: IDLE, HOLD (even byte buffered), ISSUE, WAIT_ACK, FLUSH, DONE.
REQ-017 IDLE + wr with even addr -> buffer byte, word address, target port; go HOLD.
REQ-018 IDLE + wr with odd addr -> write with ds=2'b01; go ISSUE.
REQ-019 HOLD + wr at same word address, odd -> merge, ds=2'b11; go ISSUE.
REQ-020 HOLD + wr at any other address -> issue held byte alone (ds=2'b10), retain new byte for the following cycle; new byte then handled as from IDLE after WAIT_ACK.
REQ-021 ISSUE (1 cycle): drive we=1, a, ds, d on the target port and toggle its req; other port's req unchanged.
REQ-022 WAIT_ACK: hold a/ds/d/we stable; exit when target ack == req; go IDLE, or HOLD/ISSUE for a retained byte.
REQ-023 ioctl_wait = 1 in ISSUE, WAIT_ACK, FLUSH; 0 otherwise; asserted combinationally the cycle after the strobe that caused ISSUE.
REQ-024 wr while ioctl_wait = 1: byte dropped, overrun set until reset.
REQ-025 Falling edge of ioctl_download: HOLD -> FLUSH issues held byte (ds=2'b10), waits ack, then DONE; IDLE -> DONE immediately.
REQ-026 DONE: load_done = 1; rising edge of ioctl_download clears load_done, goes IDLE.
REQ-027 wr while ioctl_download = 0 is ignored, not an overrun.
REQ-028 port*_we = 0 whenever no write is outstanding; req never toggles twice without matching ack.
REQ-029 Max latency strobe->req toggle: 1 cycle (2 for split HOLD case).

Reset
REQ-030 reset: state IDLE; ioctl_wait, load_done, overrun, port*_we = 0; port*_a, ds, d = 0.
REQ-031 port1_req/port2_req reset to current port1_ack/port2_ack values, so no spurious request.
REQ-032 reset mid-WAIT_ACK abandons the write; no further toggle until new byte.

Verification
REQ-033 wr 0x000000=0x12, then 0x000001=0x34 -> single port1 write a=0, d=0x1234, ds=2'b11, one req toggle.
REQ-034 wr 0x100003=0xAB -> port2 write a=1, d[7:0]=0xAB, ds=2'b01; port1_req unchanged.
REQ-035 wr 0x000010=0x55 then 0x000020=0x66 -> port1 write a=8 ds=2'b10, then held 0x66 at a=0x10 committed on download fall, ds=2'b10.
REQ-036 ack delayed 20 cycles; wr during wait -> ioctl_wait high throughout, byte dropped, overrun=1.
REQ-037 download falls with HOLD pending -> flush write, load_done rises the cycle after ack matches; download rises -> load_done=0.
REQ-038 reset asserted in WAIT_ACK with ack != req -> after reset req == ack, all outputs at reset values.

Source files
------------

// File: rtl/rom_loader.sv
// Packs the ioctl byte stream into 16-bit SDRAM writes and routes each one to
// port 1 (banks 0,1) or port 2 (gfx banks 2,3), using a toggle req/ack handshake.
module rom_loader #(
  parameter logic [24:0] GFX_BASE = 25'h0100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic        port1_we,
  output logic [23:1] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic        port2_we,
  output logic [23:1] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        load_done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_ISSUE, S_WAIT_ACK, S_FLUSH, S_DONE
  } state_t;

  function automatic logic f_is_gfx(input logic [24:0] addr);
    return (addr >= GFX_BASE);
  endfunction

  function automatic logic [22:0] f_word(input logic [24:0] addr);
    logic [24:0] off;
    off = f_is_gfx(addr) ? (addr - GFX_BASE) : addr;
    return 23'(off >> 1);
  endfunction

  state_t      r_state;
  logic [24:0] r_hold_addr;
  logic [7:0]  r_hold_d;
  logic        r_ret_valid;
  logic [24:0] r_ret_addr;
  logic [7:0]  r_ret_d;
  logic        r_tgt;
  logic        r_issued;
  logic        r_armed;

  logic        w_wr;
  logic        w_merge;
  logic        w_ack_ok;
  logic        w_ld;
  logic [24:0] w_ld_addr;
  logic [1:0]  w_ld_ds;
  logic [15:0] w_ld_d;
  logic        w_ld_gfx;
  logic [22:0] w_ld_a;

  assign w_wr       = ioctl_wr & ioctl_download;
  assign ioctl_wait = (r_state == S_ISSUE) | (r_state == S_WAIT_ACK) | (r_state == S_FLUSH);
  assign w_merge    = (ioctl_addr[24:1] == r_hold_addr[24:1]) & ioctl_addr[0];
  assign w_ack_ok   = r_tgt ? (port2_ack == port2_req) : (port1_ack == port1_req);
  assign w_ld_gfx   = f_is_gfx(w_ld_addr);
  assign w_ld_a     = f_word(w_ld_addr);

  // Decide when a write's address/lanes/data get loaded onto a port, and with what.
  always_comb begin
    w_ld      = 1'b0;
    w_ld_addr = r_hold_addr;
    w_ld_ds   = 2'b10;
    w_ld_d    = {r_hold_d, 8'h00};
    case (r_state)
      S_IDLE: begin
        if (w_wr && ioctl_addr[0]) begin
          w_ld      = 1'b1;
          w_ld_addr = ioctl_addr;
          w_ld_ds   = 2'b01;
          w_ld_d    = {8'h00, ioctl_dout};
        end else begin
          w_ld = 1'b0;
        end
      end
      S_HOLD: begin
        if (w_wr) begin
          w_ld = 1'b1;
          if (w_merge) begin
            w_ld_ds = 2'b11;
            w_ld_d  = {r_hold_d, ioctl_dout};
          end else begin
            w_ld_ds = 2'b10;
          end
        end else if (!ioctl_download) begin
          w_ld = 1'b1;
        end else begin
          w_ld = 1'b0;
        end
      end
      S_WAIT_ACK: begin
        if (w_ack_ok && r_ret_valid && r_ret_addr[0]) begin
          w_ld      = 1'b1;
          w_ld_addr = r_ret_addr;
          w_ld_ds   = 2'b01;
          w_ld_d    = {8'h00, r_ret_d};
        end else begin
          w_ld = 1'b0;
        end
      end
      default: w_ld = 1'b0;
    endcase
  end

  // Loader FSM with registered port and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hold_addr <= 25'd0;
      r_hold_d    <= 8'h00;
      r_ret_valid <= 1'b0;
      r_ret_addr  <= 25'd0;
      r_ret_d     <= 8'h00;
      r_tgt       <= 1'b0;
      r_issued    <= 1'b0;
      r_armed     <= 1'b0;
      load_done   <= 1'b0;
      overrun     <= 1'b0;
      port1_req   <= port1_ack;
      port2_req   <= port2_ack;
      port1_we    <= 1'b0;
      port2_we    <= 1'b0;
      port1_a     <= 23'd0;
      port2_a     <= 23'd0;
      port1_ds    <= 2'b00;
      port2_ds    <= 2'b00;
      port1_d     <= 16'h0000;
      port2_d     <= 16'h0000;
    end else begin
      if (ioctl_download) r_armed <= 1'b1;
      if (w_wr && ioctl_wait) overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_wr) begin
            if (ioctl_addr[0]) begin
              r_state <= S_ISSUE;
            end else begin
              r_hold_addr <= ioctl_addr;
              r_hold_d    <= ioctl_dout;
              r_state     <= S_HOLD;
            end
          end else if (!ioctl_download && r_armed) begin
            load_done <= 1'b1;
            r_armed   <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_HOLD: begin
          if (w_wr) begin
            // A non-matching byte splits the pair; it is replayed after this write.
            if (!w_merge) begin
              r_ret_valid <= 1'b1;
              r_ret_addr  <= ioctl_addr;
              r_ret_d     <= ioctl_dout;
            end
            r_state <= S_ISSUE;
          end else if (!ioctl_download) begin
            r_issued <= 1'b0;
            r_state  <= S_FLUSH;
          end
        end
        S_ISSUE: begin
          if (r_tgt) port2_req <= ~port2_req;
          else       port1_req <= ~port1_req;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (w_ack_ok) begin
            port1_we <= 1'b0;
            port2_we <= 1'b0;
            if (r_ret_valid) begin
              r_ret_valid <= 1'b0;
              if (r_ret_addr[0]) begin
                r_state <= S_ISSUE;
              end else begin
                r_hold_addr <= r_ret_addr;
                r_hold_d    <= r_ret_d;
                r_state     <= S_HOLD;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          if (!r_issued) begin
            if (r_tgt) port2_req <= ~port2_req;
            else       port1_req <= ~port1_req;
            r_issued <= 1'b1;
          end else if (w_ack_ok) begin
            port1_we  <= 1'b0;
            port2_we  <= 1'b0;
            load_done <= 1'b1;
            r_armed   <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (ioctl_download) begin
            load_done <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_ld) begin
        r_tgt <= w_ld_gfx;
        if (w_ld_gfx) begin
          port2_we <= 1'b1;
          port2_a  <= w_ld_a;
          port2_ds <= w_ld_ds;
          port2_d  <= w_ld_d;
        end else begin
          port1_we <= 1'b1;
          port1_a  <= w_ld_a;
          port1_ds <= w_ld_ds;
          port1_d  <= w_ld_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: expected SDRAM writes are queued as bytes are
// driven and checked by a toggle-handshake responder on each req toggle.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        ioctl_wait;
  logic        port1_req, port1_we, port2_req, port2_we;
  logic        port1_ack = 1'b1;
  logic        port2_ack = 1'b0;
  logic [23:1] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic        load_done, overrun;

  rom_loader dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_we(port1_we), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_we(port2_we), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .load_done(load_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        port;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_delay = 2;
  logic last[2];
  logic pend[2] = '{1'b0, 1'b0};
  int   cnt[2];

  // Responder: checks each req toggle against the scoreboard, acks after ack_delay.
  initial begin
    logic rq, ak, we;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d, mask;
    wr_t exp_w, got_w;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        rq = p[0] ? port2_req : port1_req;
        ak = p[0] ? port2_ack : port1_ack;
        we = p[0] ? port2_we  : port1_we;
        a  = p[0] ? port2_a   : port1_a;
        ds = p[0] ? port2_ds  : port1_ds;
        d  = p[0] ? port2_d   : port1_d;
        if (reset) begin
          last[p] = ak;
          pend[p] = 1'b0;
        end else begin
          if (rq !== last[p]) begin
            last[p] = rq;
            checks++;
            if (pend[p]) begin
              errors++;
              $display("FAIL req_double_toggle port%0d: toggled again before ack", p + 1);
            end else if (sb.size() == 0) begin
              errors++;
              $display("FAIL unexpected_write port%0d: a=%h ds=%b d=%h, expected none", p + 1, a, ds, d);
            end else begin
              exp_w = sb.pop_front();
              mask  = {{8{exp_w.ds[1]}}, {8{exp_w.ds[0]}}};
              got_w = {p[0], a, ds, d & mask};
              if (got_w !== exp_w || we !== 1'b1) begin
                errors++;
                $display("FAIL write_data: got port%0d a=%h ds=%b d=%h we=%b, expected port%0d a=%h ds=%b d=%h we=1",
                         got_w.port + 1, got_w.a, got_w.ds, got_w.d, we,
                         exp_w.port + 1, exp_w.a, exp_w.ds, exp_w.d);
              end
            end
            pend[p] = 1'b1;
            cnt[p]  = ack_delay;
          end
          if (pend[p]) begin
            if (cnt[p] == 0) begin
              pend[p] = 1'b0;
              if (p[0]) port2_ack = rq;
              else      port1_ack = rq;
            end else begin
              cnt[p]--;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wr_byte(input logic [24:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_quiet(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!ioctl_wait && !pend[0] && !pend[1]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (port1_req !== port1_ack || port2_req !== port2_ack) begin
      errors++;
      $display("FAIL reset_req: req1=%b ack1=%b req2=%b ack2=%b, expected req==ack", port1_req, port1_ack, port2_req, port2_ack);
    end
    checks++;
    if ({ioctl_wait, load_done, overrun, port1_we, port2_we} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_status: wait/done/ovr/we1/we2=%b, expected 00000", {ioctl_wait, load_done, overrun, port1_we, port2_we});
    end
    checks++;
    if ({port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d} !== 82'd0) begin
      errors++;
      $display("FAIL reset_fields: a1=%h ds1=%b d1=%h a2=%h ds2=%b d2=%h, expected 0", port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d);
    end
  endtask

  task automatic test_merge();
    logic r;
    bit ok;
    ioctl_download = 1'b1;
    @(negedge clk);
    sb.push_back({1'b0, 23'h000000, 2'b11, 16'h1234});
    wr_byte(25'h0000000, 8'h12);
    wr_byte(25'h0000001, 8'h34);
    r = port1_req;
    checks++;
    if (ioctl_wait !== 1'b1) begin
      errors++;
      $display("FAIL merge_wait: ioctl_wait=%b, expected 1", ioctl_wait);
    end
    @(negedge clk);
    checks++;
    if (port1_req === r) begin
      errors++;
      $display("FAIL merge_latency: port1_req=%b, expected toggled from %b", port1_req, r);
    end
    wait_quiet(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++;
      $display("FAIL merge_done: quiet=%0d pending=%0d, expected 1 and 0", ok, sb.size());
    end
  endtask

  task automatic test_port2();
    logic r1;
    bit ok;
    sb.push_back({1'b1, 23'h000001, 2'b01, 16'h00AB});
    r1 = port1_req;
    wr_byte(25'h0100003, 8'hAB);
    wait_quiet(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++;
      $display("FAIL port2_done: quiet=%0d pending=%0d, expected 1 and 0", ok, sb.size());
    end
    checks++;
    if (port1_req !== r1) begin
      errors++;
      $display("FAIL port2_p1req: port1_req=%b, expected %b", port1_req, r1);
    end
  endtask

  task automatic test_split_flush();
    logic r;
    bit ok, found;
    sb.push_back({1'b0, 23'h000008, 2'b10, 16'h5500});
    wr_byte(25'h0000010, 8'h55);
    wr_byte(25'h0000020, 8'h66);
    wait_quiet(ok);
    checks++;
    if (!ok || sb.size() != 0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL split_first: quiet=%0d pending=%0d load_done=%b, expected 1 0 0", ok, sb.size(), load_done);
    end
    sb.push_back({1'b0, 23'h000010, 2'b10, 16'h6600});
    r = port1_req;
    ack_delay = 3;
    ioctl_download = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (port1_req !== r && port1_ack === port1_req) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || load_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_ack: acked=%0d load_done=%b, expected 1 and 0", found, load_done);
    end
    @(negedge clk);
    #1;
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: load_done=%b, expected 1", load_done);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL flush_sb: pending=%0d, expected 0", sb.size());
    end
    ack_delay = 2;
  endtask

  task automatic test_ignored();
    logic r1, r2;
    r1 = port1_req;
    r2 = port2_req;
    wr_byte(25'h0000005, 8'h77);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (overrun !== 1'b0 || port1_req !== r1 || port2_req !== r2 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL ignored_wr: overrun=%b req1=%b req2=%b load_done=%b, expected 0 %b %b 1", overrun, port1_req, port2_req, load_done, r1, r2);
    end
    ioctl_download = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (load_done !== 1'b0) begin
      errors++;
      $display("FAIL done_clear: load_done=%b, expected 0", load_done);
    end
  endtask

  task automatic test_overrun();
    bit ok, bad;
    ack_delay = 20;
    sb.push_back({1'b0, 23'h000020, 2'b01, 16'h0077});
    wr_byte(25'h0000041, 8'h77);
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) begin
        ioctl_addr = 25'h0000043;
        ioctl_dout = 8'h88;
        ioctl_wr   = 1'b1;
      end else begin
        ioctl_wr = 1'b0;
      end
      @(negedge clk);
      #1;
      if ((pend[0] || i < 2) && ioctl_wait !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL overrun_wait: ioctl_wait dropped to 0, expected 1 while ack pending");
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: overrun=%b, expected 1", overrun);
    end
    wait_quiet(ok);
    checks++;
    if (!ok || sb.size() != 0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_end: quiet=%0d pending=%0d overrun=%b, expected 1 0 1", ok, sb.size(), overrun);
    end
    ack_delay = 2;
  endtask

  task automatic test_reset_midwait();
    ack_delay = 50;
    sb.push_back({1'b1, 23'h000002, 2'b01, 16'h0099});
    wr_byte(25'h0100005, 8'h99);
    repeat (3) @(negedge clk);
    checks++;
    if (port2_req === port2_ack) begin
      errors++;
      $display("FAIL midwait_pending: port2_req=%b port2_ack=%b, expected different", port2_req, port2_ack);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (port1_req !== port1_ack || port2_req !== port2_ack) begin
      errors++;
      $display("FAIL midwait_req: req1=%b ack1=%b req2=%b ack2=%b, expected req==ack", port1_req, port1_ack, port2_req, port2_ack);
    end
    checks++;
    if ({ioctl_wait, load_done, overrun, port1_we, port2_we} !== 5'b00000 ||
        {port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d} !== 82'd0) begin
      errors++;
      $display("FAIL midwait_outputs: status=%b a2=%h ds2=%b d2=%h, expected all 0", {ioctl_wait, load_done, overrun, port1_we, port2_we}, port2_a, port2_ds, port2_d);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (port2_req !== port2_ack) begin
      errors++;
      $display("FAIL midwait_quiet: port2_req=%b port2_ack=%b, expected equal", port2_req, port2_ack);
    end
    ack_delay = 2;
  endtask

  initial begin
    test_reset();
    test_merge();
    test_port2();
    test_split_flush();
    test_ignored();
    test_overrun();
    test_reset_midwait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
